// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and helpers for the inter-stage pipeline register.
// Holds the stall/reset encodings and the per-cycle action decoder.
package pipe_stage_reg_pkg;

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

    typedef enum logic [2:0] {
        ACT_RESET  = 3'd0,
        ACT_FLUSH  = 3'd1,
        ACT_BUBBLE = 3'd2,
        ACT_LOAD   = 3'd3,
        ACT_HOLD   = 3'd4
    } stage_act_e;

    typedef struct packed {
        logic valid;
        logic delayslot;
        logic next_delayslot;
    } stage_flags_t;

    // up=0/dn=1 cannot come from the stall controller; it is treated as a load.
    function automatic stage_act_e decode_action(input logic rst,
                                                 input logic flush,
                                                 input logic up,
                                                 input logic dn);
        stage_act_e act;
        if (rst == RST_ENABLE) begin
            act = ACT_RESET;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if ((up == STALL_ENABLE) && (dn == STALL_DISABLE)) begin
            act = ACT_BUBBLE;
        end else if (up == STALL_DISABLE) begin
            act = ACT_LOAD;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_chk.sv
// Protocol checker for the pipeline register: stall vector must be
// contiguous from stage 0, and outputs must never carry X out of reset.
module pipe_stage_reg_chk #(
    parameter int DATA_W     = 64,
    parameter int NUM_STAGES = 6,
    parameter int CNT_W      = 16
) (
    input logic                  clk,
    input logic                  rst,
    input logic [NUM_STAGES-1:0] stall,
    input logic                  out_valid,
    input logic [DATA_W-1:0]     out_data,
    input logic                  out_delayslot,
    input logic                  out_next_delayslot,
    input logic [CNT_W-1:0]      bubble_cnt,
    input logic [CNT_W-1:0]      hold_cnt
);

    // A contiguous low run of ones plus one clears every set bit.
    a_stall_contiguous: assert property (@(posedge clk) disable iff (rst)
        ((stall + NUM_STAGES'(1'b1)) & stall) == {NUM_STAGES{1'b0}})
        else $error("illegal stall vector %b", stall);

    a_outputs_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({out_valid, out_data, out_delayslot, out_next_delayslot,
                     bubble_cnt, hold_cnt}))
        else $error("unknown value on pipeline register outputs");

endmodule

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear; reset wins over clear,
// clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_next_s;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_next_s = cnt_r + W'(1'b1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall/bubble/flush handling
// and saturating bubble/hold performance counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W       = 64,
    parameter int                NUM_STAGES   = 6,
    parameter int                STAGE_IDX    = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_delayslot,
    input  logic                  in_next_delayslot,
    input  logic                  cnt_clr,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_delayslot,
    output logic                  out_next_delayslot,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      hold_cnt
);

    logic              up_s;
    logic              dn_s;
    stage_act_e        act_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_next_s;
    stage_flags_t      flags_r;
    stage_flags_t      flags_next_s;
    logic              bubble_inc_s;
    logic              hold_inc_s;

    assign up_s = stall[STAGE_IDX];
    assign dn_s = stall[STAGE_IDX+1];

    // Resolve this cycle's action in priority order.
    always_comb begin
        act_s = decode_action(rst, flush, up_s, dn_s);
    end

    // Next stage contents for each action; a bubble keeps next_delayslot so
    // the upstream decoder still sees the pending branch.
    always_comb begin
        data_next_s  = data_r;
        flags_next_s = flags_r;
        case (act_s)
            ACT_RESET, ACT_FLUSH: begin
                data_next_s  = BUBBLE_VALUE;
                flags_next_s = '{valid: 1'b0, delayslot: 1'b0, next_delayslot: 1'b0};
            end
            ACT_BUBBLE: begin
                data_next_s            = BUBBLE_VALUE;
                flags_next_s.valid     = 1'b0;
                flags_next_s.delayslot = 1'b0;
            end
            ACT_LOAD: begin
                data_next_s  = in_data;
                flags_next_s = '{valid: in_valid, delayslot: in_delayslot,
                                 next_delayslot: in_next_delayslot};
            end
            ACT_HOLD: begin
                data_next_s  = data_r;
                flags_next_s = flags_r;
            end
            default: begin
                data_next_s  = BUBBLE_VALUE;
                flags_next_s = '{valid: 1'b0, delayslot: 1'b0, next_delayslot: 1'b0};
            end
        endcase
    end

    // Stage register; reset is folded into the action decode.
    always_ff @(posedge clk) begin
        data_r  <= data_next_s;
        flags_r <= flags_next_s;
    end

    // Only stall-induced bubbles and holds count; flush and reset do not.
    always_comb begin
        bubble_inc_s = (act_s == ACT_BUBBLE);
        hold_inc_s   = (act_s == ACT_HOLD);
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (bubble_inc_s),
        .cnt (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (hold_inc_s),
        .cnt (hold_cnt)
    );

    assign out_valid          = flags_r.valid;
    assign out_data           = data_r;
    assign out_delayslot      = flags_r.delayslot;
    assign out_next_delayslot = flags_r.next_delayslot;

    pipe_stage_reg_chk #(
        .DATA_W     (DATA_W),
        .NUM_STAGES (NUM_STAGES),
        .CNT_W      (CNT_W)
    ) u_chk (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_delayslot      (out_delayslot),
        .out_next_delayslot (out_next_delayslot),
        .bubble_cnt         (bubble_cnt),
        .hold_cnt           (hold_cnt)
    );

endmodule
